instr_mem_loader: RTL and testbench

Program loader that writes into the instruction memory, which the single-cycle MIPS core only reads. It accepts a big-endian byte stream over a valid/ready handshake and assembles the bytes into 32-bit words. Each word is written to instruction memory through a one-cycle write port at consecutive word addresses starting at 0. The loader holds the core in reset (cpu_rst) until a complete image has been written.

---
 rtl/mips_pkg.sv | 16 +
 rtl/byte_to_word_packer.sv | 50 +++++
 rtl/instr_mem_loader.sv | 112 +++++++++++
 tb/tb_instr_mem_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, word geometry
// and the MIPS nop constant.
package mips_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles a big-endian byte stream into 32-bit words; a short final word is
// zero-filled so the unused slots decode as MIPS nops.
module byte_to_word_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    input  logic        last,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  idx;
    logic [31:0] acc;

    always_comb begin
        word = acc;
        if (load) begin
            case (idx)
                2'd0:    word[31:24] = data;
                2'd1:    word[23:16] = data;
                2'd2:    word[15:8]  = data;
                default: word[7:0]   = data;
            endcase
        end
    end

    assign word_full = load && (last || idx == LAST_IDX);

    // NOTE: the accumulator restarts from the nop word for every new word, so lanes
    // after an early byte_last are already zero and need no separate fill step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            acc <= NOP_WORD;
        end else if (clear || word_full) begin
            idx <= '0;
            acc <= NOP_WORD;
        end else if (load) begin
            idx <= idx + 2'd1;
            acc <= word;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a byte image into instruction memory one word per write cycle and holds
// the MIPS core in reset until the whole image has landed.
module instr_mem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic                  last_flag;
    logic                  accept;
    logic                  start_load;
    logic                  mem_full;
    logic [31:0]           word;
    logic                  word_full;

    assign accept     = byte_valid && byte_ready;
    assign start_load = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign mem_full   = ({1'b0, word_cnt} + (ADDR_WIDTH + 1)'(1)) == DEPTH_L;

    byte_to_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_load),
        .load      (accept),
        .data      (byte_data),
        .last      (byte_last),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_load) state_next = ST_RECV;
            end
            ST_RECV: begin
                if (word_full) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_flag)     state_next = ST_DONE;
                else if (mem_full) state_next = ST_ERR;
                else               state_next = ST_RECV;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: every output is decoded from state_next and registered, so the outputs
    // change on the same edge as the state they describe, with no extra cycle of lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            byte_ready   <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= NOP_WORD;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            word_cnt     <= '0;
            last_flag    <= 1'b0;
        end else begin
            state        <= state_next;
            byte_ready   <= (state_next == ST_RECV);
            wr_en        <= (state_next == ST_WRITE);
            busy         <= (state_next == ST_RECV) || (state_next == ST_WRITE);
            done         <= (state_next == ST_DONE);
            overflow_err <= (state_next == ST_ERR);
            cpu_rst      <= (state_next != ST_DONE);

            if (start_load) begin
                word_cnt  <= '0;
                last_flag <= 1'b0;
            end else if (accept && byte_last) begin
                last_flag <= 1'b1;
            end

            if (state == ST_RECV && word_full) begin
                wr_addr <= word_cnt;
                wr_data <= word;
            end

            if (state == ST_WRITE && state_next == ST_RECV) begin
                word_cnt <= word_cnt + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized bench for instr_mem_loader; expected memory images come
// from a byte-list model built inside the bench.
module tb_instr_mem_loader;

    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_last;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          overflow_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]    img[$];
    logic [31:0]   exp_q[$];
    logic [31:0]   got_data[$];
    logic [AW-1:0] got_addr[$];
    bit            ok;

    instr_mem_loader #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // Memory-side observer: records every write and checks the stream is stalled then.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            check_bit("ready_low_in_write", byte_ready, 1'b0);
        end
    end

    // Expected words: big-endian groups of four, short tail zero-filled, capped at DEPTH.
    function automatic void build_model();
        exp_q.delete();
        for (int w = 0; w * 4 < img.size() && w < DEPTH; w++) begin
            logic [31:0] v;
            v = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b < img.size()) v[31 - 8 * b -: 8] = img[w * 4 + b];
            end
            exp_q.push_back(v);
        end
    endfunction

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 32'(got_data.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(i));
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_q[i]);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap,
                             input int budget, output bit accepted);
        accepted = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = d;
            byte_last  = l;
            if (byte_ready === 1'b1) accepted = 1'b1;
        end
        if (!accepted) byte_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_image(input int gap_max, input bit with_last);
        bit acc;
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], with_last && (i == img.size() - 1),
                      $urandom_range(gap_max, 0), 40, acc);
            if (!acc) check_bit($sformatf("accept_byte%0d", i), acc, 1'b1);
        end
        idle();
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done === 1'b1 || overflow_err === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_bit({tag, "_timeout"}, n < 200, 1'b1);
    endtask

    task automatic mid_cycle_reset();
        #2 rst = 1'b1;
        #1;
        check_bit("arst_cpu_rst", cpu_rst, 1'b1);
        check_bit("arst_wr_en", wr_en, 1'b0);
        check_bit("arst_busy", busy, 1'b0);
        check_bit("arst_ready", byte_ready, 1'b0);
        check("arst_wr_addr", 32'(wr_addr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;

        #2;
        check_bit("rst_cpu_rst", cpu_rst, 1'b1);
        check_bit("rst_wr_en", wr_en, 1'b0);
        check_bit("rst_ready", byte_ready, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_ovf", overflow_err, 1'b0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_bit("idle_ready", byte_ready, 1'b0);

        // Two-word image.
        got_addr.delete(); got_data.delete();
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        pulse_start();
        check_bit("recv_busy", busy, 1'b1);
        check_bit("recv_ready", byte_ready, 1'b1);
        check_bit("recv_cpu_rst", cpu_rst, 1'b1);
        load_image(0, 1'b1);
        wait_end("two");
        build_model();
        check("two_w0_literal", exp_q[0], 32'h2008_0005);
        compare_writes("two");
        check_bit("two_done", done, 1'b1);
        check_bit("two_cpu_rst", cpu_rst, 1'b0);
        check_bit("two_busy", busy, 1'b0);

        // Partial word, zero-filled.
        got_addr.delete(); got_data.delete();
        img = '{8'hAC, 8'h01};
        pulse_start();
        check_bit("restart_cpu_rst", cpu_rst, 1'b1);
        check_bit("restart_done", done, 1'b0);
        load_image(0, 1'b1);
        wait_end("part");
        build_model();
        compare_writes("part");
        check_bit("part_done", done, 1'b1);

        // Random images with random idle gaps between bytes.
        for (int it = 0; it < 6; it++) begin
            int n;
            got_addr.delete(); got_data.delete();
            img.delete();
            n = $urandom_range(16, 1);
            for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(255, 0)));
            pulse_start();
            load_image(3, 1'b1);
            wait_end($sformatf("rand%0d", it));
            build_model();
            compare_writes($sformatf("rand%0d", it));
            check_bit($sformatf("rand%0d_done", it), done, 1'b1);
            check_bit($sformatf("rand%0d_ovf", it), overflow_err, 1'b0);
        end

        // Overflow: more than DEPTH words without byte_last.
        got_addr.delete(); got_data.delete();
        img.delete();
        for (int i = 0; i < 4 * DEPTH + 4; i++) img.push_back(8'($urandom_range(255, 0)));
        pulse_start();
        for (int i = 0; i < 4 * DEPTH; i++) begin
            send_byte(img[i], 1'b0, 0, 40, ok);
            if (!ok) check_bit($sformatf("ovf_accept%0d", i), ok, 1'b1);
        end
        send_byte(img[4 * DEPTH], 1'b0, 0, 20, ok);
        check_bit("ovf_extra_rejected", ok, 1'b0);
        idle();
        wait_end("ovf");
        build_model();
        compare_writes("ovf");
        check_bit("ovf_err", overflow_err, 1'b1);
        check_bit("ovf_cpu_rst", cpu_rst, 1'b1);
        check_bit("ovf_ready", byte_ready, 1'b0);
        check_bit("ovf_busy", busy, 1'b0);
        check_bit("ovf_done", done, 1'b0);
        pulse_start();
        check_bit("ovf_cleared", overflow_err, 1'b0);
        check_bit("ovf_restart_ready", byte_ready, 1'b1);
        got_addr.delete(); got_data.delete();
        img = '{8'h3C};
        load_image(0, 1'b1);
        wait_end("ovf_recover");
        build_model();
        compare_writes("ovf_recover");

        // Abort after six bytes: only the first word reaches memory.
        got_addr.delete(); got_data.delete();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_start();
        load_image(0, 1'b0);
        mid_cycle_reset();
        repeat (10) @(negedge clk);
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        build_model();
        compare_writes("abort");
        check_bit("abort_done", done, 1'b0);

        // Reset landing during the write cycle drops wr_en without a clock.
        pulse_start();
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_image(0, 1'b0);
        check_bit("wr_cycle_seen", wr_en, 1'b1);
        mid_cycle_reset();

        // start during RECV changes neither address nor word count.
        got_addr.delete(); got_data.delete();
        img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        pulse_start();
        send_byte(img[0], 1'b0, 0, 40, ok);
        send_byte(img[1], 1'b0, 0, 40, ok);
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i < 8; i++) begin
            send_byte(img[i], i == 7, 0, 40, ok);
            if (!ok) check_bit($sformatf("ign_accept%0d", i), ok, 1'b1);
        end
        idle();
        wait_end("ignore");
        build_model();
        compare_writes("ignore");
        check_bit("ignore_done", done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
